// File: rtl/fpga_ram_pkg.sv
// Shared types and constants for the FPGA L2 private-bank preloader.
package fpga_ram_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      READ    = 3'd2,
      DRAIN   = 3'd3,
      COMPARE = 3'd4,
      FINISH  = 3'd5
   } preload_state_e;

   localparam int         WORD_WIDTH = 32;
   localparam logic [3:0] BE_ALL     = 4'hF;

endpackage

// File: rtl/fpga_ram_preloader.sv
// Streams words into consecutive L2 bank addresses, then optionally reads the
// range back and flags a mismatch between the write and readback checksums.
module fpga_ram_preloader
   import fpga_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [CNT_WIDTH-1:0]  num_words_i,
   input  logic                  verify_i,
   input  logic                  data_valid_i,
   input  logic [WORD_WIDTH-1:0] data_i,
   output logic                  data_ready_o,
   output logic                  csn_o,
   output logic                  wen_o,
   output logic [3:0]            be_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [WORD_WIDTH-1:0] wdata_o,
   input  logic [WORD_WIDTH-1:0] rdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [WORD_WIDTH-1:0] checksum_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   preload_state_e r_state;
   preload_state_e w_state_nxt;

   logic [ADDR_WIDTH-1:0] r_base;
   logic [CNT_WIDTH-1:0]  r_num;
   logic                  r_verify;
   logic [CNT_WIDTH-1:0]  r_wr_cnt;
   logic [CNT_WIDTH-1:0]  r_rd_cnt;
   logic [WORD_WIDTH-1:0] r_checksum;
   logic [WORD_WIDTH-1:0] r_rb_sum;
   logic                  r_rd_ack;
   logic                  r_error;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_csn;
   logic                  r_wen;
   logic [3:0]            r_be;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WORD_WIDTH-1:0] r_wdata;

   logic                  w_ready;
   logic                  w_hs;
   logic                  w_wr_last;
   logic                  w_rd_last;
   logic [WORD_WIDTH-1:0] w_rb_next;

   assign w_ready   = (r_state == WRITE) && (r_wr_cnt != r_num);
   assign w_hs      = w_ready && data_valid_i;
   assign w_wr_last = w_hs && ((r_wr_cnt + CNT_ONE) == r_num);
   assign w_rd_last = ((r_rd_cnt + CNT_ONE) == r_num);
   // r_rd_ack marks the cycle in which rdata_i answers last cycle's read request
   assign w_rb_next = r_rd_ack ? (r_rb_sum + rdata_i) : r_rb_sum;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_nxt = (num_words_i == CNT_ZERO) ? FINISH : WRITE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WRITE: begin
            if (w_wr_last) begin
               w_state_nxt = r_verify ? READ : FINISH;
            end else begin
               w_state_nxt = WRITE;
            end
         end
         READ: begin
            if (w_rd_last) begin
               w_state_nxt = DRAIN;
            end else begin
               w_state_nxt = READ;
            end
         end
         DRAIN:   w_state_nxt = COMPARE;
         COMPARE: w_state_nxt = FINISH;
         FINISH:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath, counters, checksums and registered bank port
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_base     <= {ADDR_WIDTH{1'b0}};
         r_num      <= CNT_ZERO;
         r_verify   <= 1'b0;
         r_wr_cnt   <= CNT_ZERO;
         r_rd_cnt   <= CNT_ZERO;
         r_checksum <= {WORD_WIDTH{1'b0}};
         r_rb_sum   <= {WORD_WIDTH{1'b0}};
         r_rd_ack   <= 1'b0;
         r_error    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_csn      <= 1'b1;
         r_wen      <= 1'b0;
         r_be       <= 4'h0;
         r_addr     <= {ADDR_WIDTH{1'b0}};
         r_wdata    <= {WORD_WIDTH{1'b0}};
      end else begin
         r_busy   <= (w_state_nxt != IDLE);
         r_done   <= (w_state_nxt == FINISH);
         r_csn    <= 1'b1;
         r_wen    <= 1'b0;
         r_be     <= 4'h0;
         r_rd_ack <= ~r_csn & ~r_wen;
         r_rb_sum <= w_rb_next;
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_base     <= base_addr_i;
                  r_num      <= num_words_i;
                  r_verify   <= verify_i;
                  r_wr_cnt   <= CNT_ZERO;
                  r_rd_cnt   <= CNT_ZERO;
                  r_checksum <= {WORD_WIDTH{1'b0}};
                  r_rb_sum   <= {WORD_WIDTH{1'b0}};
                  r_error    <= 1'b0;
               end
            end
            WRITE: begin
               if (w_hs) begin
                  r_csn      <= 1'b0;
                  r_wen      <= 1'b1;
                  r_be       <= BE_ALL;
                  r_addr     <= r_base + r_wr_cnt[ADDR_WIDTH-1:0];
                  r_wdata    <= data_i;
                  r_wr_cnt   <= r_wr_cnt + CNT_ONE;
                  r_checksum <= r_checksum + data_i;
               end
            end
            READ: begin
               r_csn    <= 1'b0;
               r_addr   <= r_base + r_rd_cnt[ADDR_WIDTH-1:0];
               r_rd_cnt <= r_rd_cnt + CNT_ONE;
            end
            COMPARE: begin
               r_error <= (w_rb_next != r_checksum);
            end
            default: begin
            end
         endcase
      end
   end

   assign data_ready_o = w_ready;
   assign csn_o        = r_csn;
   assign wen_o        = r_wen;
   assign be_o         = r_be;
   assign addr_o       = r_addr;
   assign wdata_o      = r_wdata;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign error_o      = r_error;
   assign checksum_o   = r_checksum;

endmodule

// File: tb/tb_fpga_ram_preloader.sv
// Directed bench for fpga_ram_preloader with a synchronous bank model and access log.
module tb_fpga_ram_preloader;

   localparam int AW = 12;
   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic [AW-1:0] base_addr_i = '0;
   logic [CW-1:0] num_words_i = '0;
   logic          verify_i = 1'b0;
   logic          data_valid_i = 1'b0;
   logic [31:0]   data_i = '0;
   logic          data_ready_o;
   logic          csn_o;
   logic          wen_o;
   logic [3:0]    be_o;
   logic [AW-1:0] addr_o;
   logic [31:0]   wdata_o;
   logic [31:0]   rdata_q = '0;
   logic          busy_o;
   logic          done_o;
   logic          error_o;
   logic [31:0]   checksum_o;

   always #5 clk = ~clk;

   fpga_ram_preloader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_words_i(num_words_i), .verify_i(verify_i), .data_valid_i(data_valid_i),
      .data_i(data_i), .data_ready_o(data_ready_o), .csn_o(csn_o), .wen_o(wen_o),
      .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_q),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .checksum_o(checksum_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bank model: single-port synchronous RAM, plus a log of every access
   logic [31:0] mem [0:4095];
   logic        corrupt_en = 1'b0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          start_cyc = 0;
   int          acc_cnt = 0;
   logic        acc_we   [0:255];
   logic [11:0] acc_addr [0:255];
   logic [31:0] acc_data [0:255];
   logic [3:0]  acc_be   [0:255];
   int          acc_cyc  [0:255];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done_o) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (start_i && !busy_o && !rst_i) start_cyc <= cyc;
      if (!csn_o) begin
         if (wen_o) mem[addr_o] <= wdata_o;
         else rdata_q <= (corrupt_en && mem[addr_o] == 32'h33) ? 32'h34 : mem[addr_o];
         if (acc_cnt < 256) begin
            acc_we[acc_cnt]   <= wen_o;
            acc_addr[acc_cnt] <= addr_o;
            acc_data[acc_cnt] <= wdata_o;
            acc_be[acc_cnt]   <= be_o;
            acc_cyc[acc_cnt]  <= cyc;
         end
         acc_cnt <= acc_cnt + 1;
      end
   end

   logic [31:0] words [0:7];

   task automatic start_xfer(input logic [11:0] base, input logic [12:0] n, input logic ver);
      @(posedge clk); #1;
      start_i = 1'b1; base_addr_i = base; num_words_i = n; verify_i = ver;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic feed(input int n, input logic bubbles);
      int   idx = 0;
      int   budget = 200;
      logic tog = 1'b0;
      logic hs;
      while (idx < n && budget > 0) begin
         data_valid_i = bubbles ? ~tog : 1'b1;
         data_i = words[idx];
         tog = ~tog;
         hs = data_valid_i && data_ready_o;
         @(posedge clk); #1;
         if (hs) idx++;
         budget--;
      end
      data_valid_i = 1'b0;
      chk("feed_count", 32'(idx), 32'(n));
   endtask

   task automatic wait_done(input int pre);
      int budget = 100;
      while (done_cnt == pre && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", 32'(done_cnt - pre), 32'd1);
   endtask

   task automatic check_wr(input string tag, input int first, input int n,
                           input logic [11:0] base, input int gap);
      logic [11:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + 12'(i);
         chk({tag, "_we"},   32'(acc_we[first+i]), 32'd1);
         chk({tag, "_addr"}, 32'(acc_addr[first+i]), 32'(a));
         chk({tag, "_data"}, acc_data[first+i], words[i]);
         chk({tag, "_be"},   32'(acc_be[first+i]), 32'hF);
         if (i > 0) chk({tag, "_cyc"}, 32'(acc_cyc[first+i]), 32'(acc_cyc[first] + gap * i));
      end
   endtask

   task automatic check_rd(input string tag, input int first, input int n, input logic [11:0] base);
      logic [11:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + 12'(i);
         chk({tag, "_we"},   32'(acc_we[first+i]), 32'd0);
         chk({tag, "_addr"}, 32'(acc_addr[first+i]), 32'(a));
         chk({tag, "_be"},   32'(acc_be[first+i]), 32'h0);
         if (i > 0) chk({tag, "_cyc"}, 32'(acc_cyc[first+i]), 32'(acc_cyc[first] + i));
      end
   endtask

   initial begin
      int pre;
      int pd;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_csn", 32'(csn_o), 32'd1);
      chk("rst_wen", 32'(wen_o), 32'd0);
      chk("rst_be", 32'(be_o), 32'd0);
      chk("rst_addr", 32'(addr_o), 32'd0);
      chk("rst_wdata", wdata_o, 32'd0);
      chk("rst_ready", 32'(data_ready_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_error", 32'(error_o), 32'd0);
      chk("rst_checksum", checksum_o, 32'd0);
      rst_i = 1'b0;

      // Basic write, valid held high
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'h010, 13'd4, 1'b0);
      feed(4, 1'b0);
      wait_done(pd);
      chk("basic_nacc", 32'(acc_cnt - pre), 32'd4);
      check_wr("basic", pre, 4, 12'h010, 1);
      chk("basic_checksum", checksum_o, 32'hAA);
      chk("basic_error", 32'(error_o), 32'd0);
      chk("basic_busy", 32'(busy_o), 32'd0);

      // Bubbles in valid: writes every other cycle, still contiguous addresses
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'h010, 13'd4, 1'b0);
      feed(4, 1'b1);
      wait_done(pd);
      chk("bub_nacc", 32'(acc_cnt - pre), 32'd4);
      check_wr("bub", pre, 4, 12'h010, 2);
      chk("bub_checksum", checksum_o, 32'hAA);

      // Verify pass
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'h020, 13'd3, 1'b1);
      feed(3, 1'b0);
      wait_done(pd);
      chk("vp_nacc", 32'(acc_cnt - pre), 32'd6);
      check_wr("vp_wr", pre, 3, 12'h020, 1);
      check_rd("vp_rd", pre + 3, 3, 12'h020);
      chk("vp_rd_after_wr", 32'(acc_cyc[pre+3] > acc_cyc[pre+2]), 32'd1);
      chk("vp_done_cyc", 32'(done_cyc), 32'(acc_cyc[pre+5] + 2));
      chk("vp_checksum", checksum_o, 32'h66);
      chk("vp_error", 32'(error_o), 32'd0);

      // Verify fail: 0x33 read back as 0x34
      corrupt_en = 1'b1;
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'h040, 13'd3, 1'b1);
      feed(3, 1'b0);
      wait_done(pd);
      chk("vf_nacc", 32'(acc_cnt - pre), 32'd6);
      chk("vf_error", 32'(error_o), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("vf_error_held", 32'(error_o), 32'd1);
      corrupt_en = 1'b0;

      // Wrap around the top of the bank; start also clears the sticky error
      words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'hFFE, 13'd3, 1'b0);
      chk("vf_error_cleared", 32'(error_o), 32'd0);
      feed(3, 1'b0);
      wait_done(pd);
      chk("wrap_nacc", 32'(acc_cnt - pre), 32'd3);
      check_wr("wrap", pre, 3, 12'hFFE, 1);
      chk("wrap_checksum", checksum_o, 32'h6);

      // Zero length
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'h100, 13'd0, 1'b0);
      wait_done(pd);
      chk("zero_nacc", 32'(acc_cnt - pre), 32'd0);
      chk("zero_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));
      chk("zero_checksum", checksum_o, 32'd0);

      // Reset after two of five words
      words[0] = 32'hA; words[1] = 32'hB; words[2] = 32'hC; words[3] = 32'hD; words[4] = 32'hE;
      pre = acc_cnt;
      start_xfer(12'h200, 13'd5, 1'b0);
      feed(2, 1'b0);
      data_valid_i = 1'b1; data_i = words[2]; rst_i = 1'b1;
      @(posedge clk); #1;
      chk("mrst_csn", 32'(csn_o), 32'd1);
      chk("mrst_busy", 32'(busy_o), 32'd0);
      chk("mrst_ready", 32'(data_ready_o), 32'd0);
      rst_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      data_valid_i = 1'b0;
      chk("mrst_nacc", 32'(acc_cnt - pre), 32'd2);

      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
      pre = acc_cnt; pd = done_cnt;
      start_xfer(12'h300, 13'd4, 1'b0);
      feed(4, 1'b0);
      wait_done(pd);
      chk("post_nacc", 32'(acc_cnt - pre), 32'd4);
      check_wr("post", pre, 4, 12'h300, 1);
      chk("post_checksum", checksum_o, 32'hAA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fpga_ram_preloader.md
Name: fpga_ram_preloader

Overview:
- Initiator for the single-port FPGA L2 private-bank interface (csn/wen/be/addr/wdata/rdata).
- Takes a valid/ready stream of 32-bit words and writes it to consecutive bank addresses from a base address.
- Optionally reads the range back and compares a 32-bit additive checksum of the readback against that of the written data.
- Sits between the debug/boot preload path and one L2 private bank on the FPGA target.

Parameters:
- ADDR_WIDTH, 12, word-address width of the bank port; addresses wrap modulo 2^ADDR_WIDTH.
- CNT_WIDTH, ADDR_WIDTH+1, width of the word-count input; allows a full-bank count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle start pulse; honoured only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first word address; sampled on an accepted start.
- num_words_i  in  CNT_WIDTH  words to transfer; sampled on an accepted start.
- verify_i  in  1  enables the readback phase; sampled on an accepted start.
- data_valid_i  in  1  stream word valid.
- data_i  in  32  stream word.
- data_ready_o  out  1  stream ready.
- csn_o  out  1  bank chip select, active-low.
- wen_o  out  1  bank write enable, active-high (1 = write).
- be_o  out  4  byte enables; 4'hF on writes, 4'h0 on reads.
- addr_o  out  ADDR_WIDTH  bank word address.
- wdata_o  out  32  bank write data.
- rdata_i  in  32  bank read data; valid one cycle after a read request.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at completion.
- error_o  out  1  checksum mismatch; sticky until the next accepted start.
- checksum_o  out  32  sum of written words modulo 2^32; held after done.

Behaviour:
- Reset values:
  - csn_o=1, wen_o=0, be_o=0, addr_o=0, wdata_o=0.
  - data_ready_o=0, busy_o=0, done_o=0, error_o=0, checksum_o=0.
  - FSM in IDLE.
  - Reset asserted mid-operation aborts immediately; no further bank accesses occur.
- All bank-port outputs are registered. csn_o is high in every cycle without a request.
- FSM states:
  - IDLE: on start_i, latch base, count and verify; clear checksum, readback sum and error. If num_words_i==0, go to FINISH; otherwise go to WRITE.
  - WRITE:
    - data_ready_o=1 combinationally, except when the write count has reached N.
    - Each handshake (valid & ready) registers one write for the next cycle: csn_o=0, wen_o=1, be_o=F, addr_o=base+i, wdata_o=data_i. It also adds data_i to the checksum.
    - Throughput is one word per cycle; bubbles in valid produce idle cycles (csn_o=1).
    - After the N-th handshake: go to READ if verify was latched, else to FINISH.
  - READ:
    - Issues N back-to-back reads (csn_o=0, wen_o=0, be_o=0, addr_o=base+j), one per cycle.
    - rdata_i is added to the readback sum one cycle after each read.
    - After the last read is issued, go to DRAIN.
  - DRAIN: one cycle to accumulate the final rdata_i, then go to COMPARE.
  - COMPARE: set error_o if the readback sum != checksum, then go to FINISH.
  - FINISH: done_o=1 for this single cycle, then go to IDLE.
- Write and read phases never overlap; the first read register follows the last write register by at least one cycle.
- Address arithmetic is ADDR_WIDTH-bit and wraps silently (base 0xFFE with N=3 gives 0xFFE, 0xFFF, 0x000).
- start_i while busy is ignored. data_valid_i outside WRITE is not acknowledged.
- Counters are CNT_WIDTH bits. N = 2^ADDR_WIDTH must complete without counter overflow.

Decomposition:
- Package fpga_ram_pkg holds:
  - preload_state_e (IDLE, WRITE, READ, DRAIN, COMPARE, FINISH).
  - WORD_WIDTH=32.
  - BE_ALL=4'hF.
- The design is a single module; no sub-module is warranted (the checksum is two adders).

Test Plan:
- Basic write: base=0x010, N=4, verify=0; words 0x11,0x22,0x33,0x44 with valid held high -> four consecutive write cycles at 0x010..0x013, be_o=F; checksum_o=0xAA; done_o pulses once; error_o=0.
- Backpressure/bubbles: same transfer with valid toggling 1,0,1,0 -> writes only on handshake cycles; csn_o=1 in bubble cycles; addresses still contiguous.
- Verify pass: N=3, verify=1, bank model echoes the written data -> three read cycles (wen_o=0) at base..base+2; done_o after DRAIN and COMPARE; error_o=0.
- Verify fail: bank model corrupts one readback word (0x33 returned as 0x34) -> error_o=1 at done_o and held until the next start, where it clears.
- Wrap and zero length: base=0xFFE, N=3 -> addresses 0xFFE, 0xFFF, 0x000. Separately, N=0 -> no csn_o assertion, done_o one cycle after start.
- Reset mid-write: assert rst_i after 2 of 5 words -> next cycle csn_o=1, busy_o=0, data_ready_o=0; a subsequent start behaves normally.
